// File: rtl/ssm_tile_accum_ctrl_if.sv
// ssm_tile_accum_ctrl_if
//   Bundles the tile handshake, the shared fp16 adder interface, the clear
//   strobe, the readout port and the status pulses of ssm_tile_accum_ctrl.
//   slave  : the accumulation controller side.
//   master : the side that offers tiles, hosts the adder and reads results.
//
//   clear          master->slave  pulse, zero the accumulator (IDLE only)
//   tile_valid     master->slave  tile offered
//   tile_ready     slave->master  controller can accept a tile
//   h_off, p_off   master->slave  tile origin (head, P element)
//   tile_y_flat    master->slave  H_TILE*P_TILE words, word i at [DW*i +: DW]
//   add_a, add_b   slave->master  adder operands (accumulator, tile word)
//   add_valid_in   slave->master  adder issue strobe
//   add_result     master->slave  adder sum
//   add_valid_out  master->slave  sum valid, results return in issue order
//   rd_addr        master->slave  readout index h*P+p
//   rd_data        slave->master  registered accumulator word
//   busy           slave->master  controller not IDLE
//   tile_done      slave->master  pulse, tile fully written back
//   err            slave->master  pulse, out-of-range tile rejected
interface ssm_tile_accum_ctrl_if #(
    parameter int H      = 24,
    parameter int P      = 64,
    parameter int H_TILE = 4,
    parameter int P_TILE = 4,
    parameter int DW     = 16
);
    localparam int HW = $clog2(H);
    localparam int PW = $clog2(P);
    localparam int AW = $clog2(H * P);

    logic                        clear;
    logic                        tile_valid;
    logic                        tile_ready;
    logic [HW-1:0]               h_off;
    logic [PW-1:0]               p_off;
    logic [H_TILE*P_TILE*DW-1:0] tile_y_flat;
    logic [DW-1:0]               add_a;
    logic [DW-1:0]               add_b;
    logic                        add_valid_in;
    logic [DW-1:0]               add_result;
    logic                        add_valid_out;
    logic [AW-1:0]               rd_addr;
    logic [DW-1:0]               rd_data;
    logic                        busy;
    logic                        tile_done;
    logic                        err;

    modport slave (
        input  clear, tile_valid, h_off, p_off, tile_y_flat,
               add_result, add_valid_out, rd_addr,
        output tile_ready, add_a, add_b, add_valid_in,
               rd_data, busy, tile_done, err
    );

    modport master (
        output clear, tile_valid, h_off, p_off, tile_y_flat,
               add_result, add_valid_out, rd_addr,
        input  tile_ready, add_a, add_b, add_valid_in,
               rd_data, busy, tile_done, err
    );
endinterface

// File: rtl/ssm_tile_accum_ctrl.sv
// ssm_tile_accum_ctrl
//   Accumulates tiles of fp16 y outputs into an H*P accumulator using a shared,
//   in-order pipelined fp16 adder. Each tile word k is read-modify-written at
//   index (h_off + k/P_TILE)*P + (p_off + k%P_TILE). Issued indices are kept in
//   a small FIFO so that returning sums are written back to the right entry.
//
//   clk  : clock
//   rst  : synchronous active-high reset (accumulator contents are kept)
//   bus  : ssm_tile_accum_ctrl_if.slave (tile handshake, adder, readout, status)
module ssm_tile_accum_ctrl #(
    parameter int H            = 24,
    parameter int P            = 64,
    parameter int H_TILE       = 4,
    parameter int P_TILE       = 4,
    parameter int DW           = 16,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    ssm_tile_accum_ctrl_if.slave  bus
);
    localparam int N  = H_TILE * P_TILE;
    localparam int HW = $clog2(H);
    localparam int PW = $clog2(P);
    localparam int AW = $clog2(H * P);
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int FW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam int CW = FW + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]      state;
    logic [KW-1:0]   k;
    logic [AW-1:0]   clr_idx;
    logic [HW-1:0]   h_base;
    logic [PW-1:0]   p_base;
    logic [N*DW-1:0] tile_q;

    logic [DW-1:0]   acc      [H*P];
    logic [AW-1:0]   fifo_mem [MAX_INFLIGHT];
    logic [FW-1:0]   wr_ptr;
    logic [FW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic            accept;
    logic            range_bad;
    logic            pop;
    logic            fifo_full;
    logic            issue;
    logic [HW-1:0]   h_sel;
    logic [PW-1:0]   p_sel;
    logic [KW-1:0]   k_sel;
    logic [AW-1:0]   issue_idx;
    logic [DW-1:0]   issue_word;

    // clear wins over a tile offered in the same IDLE cycle
    assign bus.tile_ready = !rst && (state == S_IDLE) && !bus.clear;
    assign bus.busy       = (state != S_IDLE);
    assign accept         = bus.tile_valid && bus.tile_ready;
    assign range_bad      = (int'(bus.h_off) > H - H_TILE) || (int'(bus.p_off) > P - P_TILE);

    // results arriving with nothing outstanding (e.g. after a reset) are dropped
    assign pop = !rst && bus.add_valid_out && (count != '0);

    // a pop in the same cycle frees a slot, so issue can continue at full depth
    assign fifo_full = (count == CW'(MAX_INFLIGHT)) && !pop;

    // element 0 is issued directly on the handshake cycle from the live inputs;
    // the remaining elements come from the captured tile in ISSUE
    assign issue = (accept && !range_bad) || ((state == S_ISSUE) && !fifo_full);

    assign h_sel      = (state == S_ISSUE) ? h_base : bus.h_off;
    assign p_sel      = (state == S_ISSUE) ? p_base : bus.p_off;
    assign k_sel      = (state == S_ISSUE) ? k : '0;
    assign issue_word = (state == S_ISSUE) ? tile_q[DW*int'(k) +: DW] : bus.tile_y_flat[DW-1:0];

    always_comb begin
        int h_abs;
        int p_abs;
        h_abs     = int'(h_sel) + int'(k_sel) / P_TILE;
        p_abs     = int'(p_sel) + int'(k_sel) % P_TILE;
        issue_idx = AW'(h_abs * P + p_abs);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            k                <= '0;
            clr_idx          <= '0;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            bus.add_valid_in <= 1'b0;
            bus.add_a        <= '0;
            bus.add_b        <= '0;
            bus.tile_done    <= 1'b0;
            bus.err          <= 1'b0;
            bus.rd_data      <= '0;
        end else begin
            bus.rd_data      <= acc[bus.rd_addr];
            bus.add_valid_in <= issue;
            bus.tile_done    <= 1'b0;
            bus.err          <= 1'b0;

            if (issue) begin
                bus.add_a <= acc[issue_idx];
                bus.add_b <= issue_word;
                wr_ptr    <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(issue) - CW'(pop);

            case (state)
                S_IDLE: begin
                    if (bus.clear) begin
                        clr_idx <= '0;
                        state   <= S_CLEAR;
                    end else if (accept) begin
                        h_base <= bus.h_off;
                        p_base <= bus.p_off;
                        tile_q <= bus.tile_y_flat;
                        if (range_bad) begin
                            bus.err <= 1'b1;
                        end else begin
                            k     <= KW'(1);
                            state <= (N == 1) ? S_DRAIN : S_ISSUE;
                        end
                    end
                end
                S_CLEAR: begin
                    clr_idx <= clr_idx + 1'b1;
                    if (clr_idx == AW'(H * P - 1)) begin
                        state <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    if (!fifo_full) begin
                        k <= k + 1'b1;
                        if (k == KW'(N - 1)) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // leave once the last outstanding sum is written back this cycle
                    if ((count - CW'(pop)) == '0) begin
                        bus.tile_done <= 1'b1;
                        state         <= S_DONE;
                    end
                end
                S_DONE: begin
                    k     <= '0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            fifo_mem[wr_ptr] <= issue_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && (state == S_CLEAR)) begin
            acc[clr_idx] <= '0;
        end else if (pop) begin
            acc[fifo_mem[rd_ptr]] <= bus.add_result;
        end
    end
endmodule

// File: tb/tb_ssm_tile_accum_ctrl.sv
// tb_ssm_tile_accum_ctrl
//   Directed bench for ssm_tile_accum_ctrl with a configurable-latency adder
//   stand-in. Expected readout words and status events are queued when the
//   stimulus is issued; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_ssm_tile_accum_ctrl;
    localparam int H = 24, P = 64, H_TILE = 4, P_TILE = 4, DW = 16, MAX_INFLIGHT = 8;
    localparam int N  = H_TILE * P_TILE;
    localparam int HP = H * P;
    localparam int HW = $clog2(H);
    localparam int PW = $clog2(P);
    localparam int AW = $clog2(HP);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ssm_tile_accum_ctrl_if #(.H(H), .P(P), .H_TILE(H_TILE), .P_TILE(P_TILE), .DW(DW)) bus ();

    ssm_tile_accum_ctrl #(.H(H), .P(P), .H_TILE(H_TILE), .P_TILE(P_TILE), .DW(DW),
                          .MAX_INFLIGHT(MAX_INFLIGHT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // small fp16 values used by the stimulus: integers 0..9
    function automatic int to_int(input logic [15:0] f);
        case (f)
            16'h0000: return 0;
            16'h3C00: return 1;
            16'h4000: return 2;
            16'h4200: return 3;
            16'h4400: return 4;
            16'h4500: return 5;
            16'h4600: return 6;
            16'h4700: return 7;
            16'h4800: return 8;
            16'h4880: return 9;
            default:  return 1000;
        endcase
    endfunction

    function automatic logic [15:0] from_int(input int v);
        case (v)
            0: return 16'h0000;
            1: return 16'h3C00;
            2: return 16'h4000;
            3: return 16'h4200;
            4: return 16'h4400;
            5: return 16'h4500;
            6: return 16'h4600;
            7: return 16'h4700;
            8: return 16'h4800;
            9: return 16'h4880;
            default: return 16'hFFFF;
        endcase
    endfunction

    // adder stand-in: in-order pipeline, latency lat (1..16)
    int          lat = 3;
    logic        pv [16] = '{default: 1'b0};
    logic [15:0] ps [16] = '{default: 16'h0000};
    logic        stray_v = 1'b0;
    logic [15:0] stray_d = 16'h0000;

    always @(posedge clk) begin
        pv[0] <= bus.add_valid_in;
        ps[0] <= from_int(to_int(bus.add_a) + to_int(bus.add_b));
        for (int i = 1; i < 16; i++) begin
            pv[i] <= pv[i-1];
            ps[i] <= ps[i-1];
        end
    end

    assign bus.add_valid_out = pv[lat-1] | stray_v;
    assign bus.add_result    = stray_v ? stray_d : ps[lat-1];

    // scoreboard state
    int          model [HP];
    logic [15:0] rd_q [$];
    int          rd_a_q [$];
    logic [1:0]  ev_q [$];       // 2'b01 tile_done, 2'b10 err
    int          issue_cyc [$];
    int          out_cyc [$];
    int          done_cyc = -1;
    logic        rd_req = 1'b0;
    logic        rd_req_d = 1'b0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rd_req_d <= rd_req;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (rd_req_d) begin
                if (rd_q.size() == 0) begin
                    chk("rd queue underflow", 1'b1, 1'b0);
                end else begin
                    logic [15:0] e;
                    int a;
                    e = rd_q.pop_front();
                    a = rd_a_q.pop_front();
                    chk($sformatf("rd_data[%0d]", a), bus.rd_data, e);
                end
            end
            if (bus.tile_done || bus.err) begin
                logic [1:0] act;
                act = {bus.err, bus.tile_done};
                if (ev_q.size() == 0) chk("unexpected status pulse", act, 2'b00);
                else                  chk("status pulse kind", act, ev_q.pop_front());
                if (bus.tile_done) done_cyc = cyc;
            end
            if (bus.add_valid_in) issue_cyc.push_back(cyc);
            if (bus.add_valid_out && !stray_v) out_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_all();
        for (int a = 0; a < HP; a++) begin
            bus.rd_addr = AW'(a);
            rd_req = 1'b1;
            rd_q.push_back(from_int(model[a]));
            rd_a_q.push_back(a);
            tick();
        end
        rd_req = 1'b0;
        tick();
    endtask

    // pulse clear (optionally with a tile offered) and count CLEAR cycles
    task automatic do_clear(input bit with_tile);
        int n;
        n = 0;
        bus.clear = 1'b1;
        bus.tile_valid = with_tile;
        #1;
        chk("tile_ready low with clear", bus.tile_ready, 1'b0);
        tick();
        bus.clear = 1'b0;
        bus.tile_valid = 1'b0;
        issue_cyc.delete();
        while (bus.busy && n < HP + 100) begin
            n++;
            tick();
        end
        chk("clear busy cycles", n, HP);
        chk("tile_ready after clear", bus.tile_ready, 1'b1);
        for (int a = 0; a < HP; a++) model[a] = 0;
    endtask

    // offer a tile; when finish=1 wait for it to complete and update the model
    task automatic send_tile(input int h, input int p, input logic [N*DW-1:0] flat,
                             input bit finish, output int t_hs);
        int budget;
        bit bad;
        budget = 0;
        bad = (h > H - H_TILE) || (p > P - P_TILE);
        bus.h_off = HW'(h);
        bus.p_off = PW'(p);
        bus.tile_y_flat = flat;
        bus.tile_valid = 1'b1;
        #1;
        while (!bus.tile_ready && budget < 4000) begin
            tick();
            budget++;
        end
        chk("tile_ready at offer", bus.tile_ready, 1'b1);
        t_hs = cyc;
        issue_cyc.delete();
        out_cyc.delete();
        done_cyc = -1;
        if (finish) begin
            ev_q.push_back(bad ? 2'b10 : 2'b01);
            if (!bad) begin
                for (int k = 0; k < N; k++) begin
                    int idx;
                    idx = (h + k / P_TILE) * P + p + k % P_TILE;
                    model[idx] = model[idx] + to_int(flat[16*k +: 16]);
                end
            end
        end
        tick();
        bus.tile_valid = 1'b0;
        if (finish) begin
            budget = 0;
            while (bus.busy && budget < 500) begin
                tick();
                budget++;
            end
            chk("busy low after tile", bus.busy, 1'b0);
            tick();
            tick();
        end
    endtask

    logic [N*DW-1:0] ones;
    logic [N*DW-1:0] mixed;
    int t;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.clear = 1'b0;
        bus.tile_valid = 1'b0;
        bus.h_off = '0;
        bus.p_off = '0;
        bus.tile_y_flat = '0;
        bus.rd_addr = '0;
        for (int k = 0; k < N; k++) begin
            ones[16*k +: 16]  = 16'h3C00;
            mixed[16*k +: 16] = from_int(1 + k % 3);
        end

        // reset values
        tick();
        chk("reset tile_ready", bus.tile_ready, 1'b0);
        chk("reset busy", bus.busy, 1'b0);
        chk("reset add_valid_in", bus.add_valid_in, 1'b0);
        chk("reset add_a", bus.add_a, 16'h0000);
        chk("reset add_b", bus.add_b, 16'h0000);
        chk("reset tile_done", bus.tile_done, 1'b0);
        chk("reset err", bus.err, 1'b0);
        chk("reset rd_data", bus.rd_data, 16'h0000);
        tick();
        rst = 1'b0;
        #1;
        chk("tile_ready in IDLE", bus.tile_ready, 1'b1);
        tick();

        // clear and read everything back as zero
        do_clear(1'b0);
        read_all();

        // one tile of 1.0 at the origin, adder latency 3
        lat = 3;
        send_tile(0, 0, ones, 1'b1, t);
        chk("lat3 issue count", issue_cyc.size(), N);
        if (issue_cyc.size() == N) begin
            chk("lat3 first issue cycle", issue_cyc[0], t + 1);
            chk("lat3 last issue cycle", issue_cyc[N-1], t + N);
            chk("lat3 tile_done after last issue", done_cyc - issue_cyc[N-1], 4);
        end
        read_all();

        // same tile twice more: 2.0 then 3.0
        send_tile(0, 0, ones, 1'b1, t);
        read_all();
        send_tile(0, 0, ones, 1'b1, t);
        read_all();

        // adder latency 12 throttles on the in-flight limit; far-corner tile
        lat = 12;
        do_clear(1'b0);
        send_tile(H - H_TILE, P - P_TILE, mixed, 1'b1, t);
        chk("lat12 issue count", issue_cyc.size(), N);
        chk("lat12 writeback count", out_cyc.size(), N);
        if (issue_cyc.size() == N && out_cyc.size() == N) begin
            chk("lat12 issue 8 cycle", issue_cyc[MAX_INFLIGHT-1], t + MAX_INFLIGHT);
            chk("lat12 resume after first pop", issue_cyc[MAX_INFLIGHT], out_cyc[0] + 1);
            chk("lat12 first writeback cycle", out_cyc[0], t + 1 + 12);
            chk("lat12 tile_done after last writeback", done_cyc, out_cyc[N-1] + 1);
        end
        read_all();

        // out-of-range tiles: err pulse, no adds, accumulator untouched
        send_tile(22, 0, ones, 1'b1, t);
        chk("h_off=22 issue count", issue_cyc.size(), 0);
        chk("tile_ready after err", bus.tile_ready, 1'b1);
        send_tile(0, 61, ones, 1'b1, t);
        chk("p_off=61 issue count", issue_cyc.size(), 0);
        read_all();

        // reset mid-ISSUE with long adder latency, then stray results
        send_tile(4, 8, ones, 1'b0, t);
        repeat (4) tick();
        chk("mid-issue busy", bus.busy, 1'b1);
        rst = 1'b1;
        tick();
        chk("tile_ready during reset", bus.tile_ready, 1'b0);
        rst = 1'b0;
        tick();
        chk("add_valid_in after reset", bus.add_valid_in, 1'b0);
        chk("busy after reset", bus.busy, 1'b0);
        chk("tile_ready after reset", bus.tile_ready, 1'b1);
        repeat (16) tick();
        stray_d = 16'h4400;
        stray_v = 1'b1;
        tick();
        tick();
        stray_v = 1'b0;
        tick();
        chk("busy after strays", bus.busy, 1'b0);
        read_all();

        // clear and tile_valid together: clear wins, tile not accepted
        do_clear(1'b1);
        chk("no issue on clear+tile", issue_cyc.size(), 0);
        read_all();

        tick();
        chk("pending status events", ev_q.size(), 0);
        chk("pending reads", rd_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ssm_tile_accum_ctrl.md
Name: ssm_tile_accum_ctrl

Overview:
- Hardware replacement for the host-side y accumulation loop of the tiled SSM flow.
- Accepts one tile of y outputs (H_TILE*P_TILE fp16 words) from ssm_block_fp16_top, plus that tile's (h_off, p_off) origin.
- Sequences a shared, in-order pipelined fp16 adder (fp16_add_wrapper interface) to add each word into an internal H*P accumulator, issuing up to one add per cycle.
- Provides clear and readout of the accumulator.

Parameters:
H, 24, total heads
P, 64, head dimension
H_TILE, 4, heads per tile
P_TILE, 4, P elements per tile
DW, 16, data width (fp16)
MAX_INFLIGHT, 8, maximum outstanding adds; depth of the write-address FIFO (power of 2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
clear  in  1  pulse; zero the accumulator (honoured only in IDLE)
tile_valid  in  1  tile offered
tile_ready  out  1  controller can accept a tile
h_off  in  $clog2(H)  tile head origin
p_off  in  $clog2(P)  tile P origin
tile_y_flat  in  H_TILE*P_TILE*DW  element i at [DW*i +: DW]
add_a  out  DW  accumulator operand
add_b  out  DW  tile operand
add_valid_in  out  1  issue strobe to adder
add_result  in  DW  adder sum
add_valid_out  in  1  sum valid (in order)
rd_addr  in  $clog2(H*P)  readout index h*P+p
rd_data  out  DW  accumulator word, registered
busy  out  1  not IDLE
tile_done  out  1  one-cycle pulse, tile fully written back
err  out  1  one-cycle pulse, out-of-range tile rejected

Behaviour:
- Reset values:
  - tile_ready=0 during the reset cycle, then 1 in IDLE.
  - add_valid_in=0, add_a=add_b=0, busy=0, tile_done=0, err=0, rd_data=0.
  - FSM goes to IDLE; address FIFO and counters are emptied.
  - Accumulator contents are not reset; a clear is required before use.
- States: IDLE, CLEAR, ISSUE, DRAIN, DONE.
- IDLE:
  - tile_ready=1.
  - If clear=1, go to CLEAR; clear has priority over tile_valid, and tile_ready is held 0 in that cycle.
  - Else, if tile_valid&tile_ready, capture tile_y_flat, h_off and p_off.
    - Out-of-range tile (h_off>H-H_TILE or p_off>P-P_TILE): pulse err next cycle, issue no adds, stay IDLE.
    - Otherwise go to ISSUE.
- CLEAR: write 0 to one entry per cycle, index 0..H*P-1, then return to IDLE. Takes H*P cycles.
- ISSUE:
  - Element counter k runs 0..H_TILE*P_TILE-1.
  - Index mapping: h_rel=k/P_TILE, p_rel=k%P_TILE, idx=(h_off+h_rel)*P+(p_off+p_rel).
  - Each cycle where the FIFO is not full:
    - add_a<=acc[idx], add_b<=tile word k, add_valid_in<=1.
    - Push idx to the FIFO; k++.
  - FIFO full: add_valid_in<=0 and k holds.
  - After the last issue, go to DRAIN.
- Writeback (any state):
  - On add_valid_out with the FIFO non-empty: acc[FIFO head]<=add_result, pop.
  - add_valid_out with the FIFO empty is ignored; this covers stale results after a reset.
  - Push and pop in the same cycle are both performed.
- No RAW hazard handling is needed:
  - Indices are distinct within a tile.
  - tile_ready=0 outside IDLE, so tiles never overlap.
- DRAIN: wait until the FIFO is empty and no pop is pending, then go to DONE.
- DONE: tile_done=1 for one cycle, then IDLE.
- Latency:
  - Handshake in cycle T gives first add_valid_in at T+1.
  - With no stall, the last issue is at T+H_TILE*P_TILE.
  - tile_done fires the cycle after the final writeback.
- Readout: rd_data<=acc[rd_addr] every cycle (1-cycle latency). Valid in any state; reading an entry in flight returns its old value.
- busy=1 in CLEAR, ISSUE, DRAIN and DONE.
- Reset mid-operation: the in-flight tile is abandoned and partial sums stay in the accumulator.

Test Plan:
- Reset, clear, then read all H*P entries -> every rd_data=0x0000, busy low after exactly H*P cycles, tile_ready=1.
- Clear, tile (h_off=0,p_off=0) all 0x3C00, adder latency 3 -> entries 0..3, 64..67, 128..131, 192..195 read 0x3C00, all others 0x0000; add_valid_in high 16 consecutive cycles; tile_done 4 cycles after the last issue.
- Same tile offered twice -> affected entries read 0x4000; add the tile again with all words 0x3C00 -> entries read 0x4200.
- Adder latency 12 with MAX_INFLIGHT=8 -> add_valid_in drops after 8 issues, resumes one cycle after the first pop, all 16 writebacks land correctly.
- Tile h_off=22 (H_TILE=4) -> err pulse, no add_valid_in, accumulator unchanged, tile_ready back to 1.
- Reset asserted mid-ISSUE, then 2 stray add_valid_out -> no accumulator writes, FSM in IDLE, tile_ready=1 after reset; clear and tile_valid in the same IDLE cycle -> CLEAR entered, tile not accepted.
